// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, pause, abort, and one-shot or
// auto-reload modes; pulses tc when the count reaches its terminal value.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             handshake;

    assign handshake = load_valid && (state_q == IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    reload_d = load_value;
                    mode_d   = auto_reload;
                    if (load_value == ZERO) begin
                        // Zero-length timer: expires on the handshake itself.
                        count_d = ZERO;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = load_value;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    count_d = ZERO;
                    state_d = IDLE;
                end else if (en) begin
                    if (count_q == ONE) begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = ZERO;
                            state_d = IDLE;
                        end
                    end else if (count_q != ZERO) begin
                        count_d = count_q - ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                count_d = ZERO;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected outputs are queued per cycle and
// compared after each rising edge.
module tb_countdown_timer;

    localparam int W = 8;

    typedef struct {
        string        tag;
        logic [W-1:0] count;
        logic         busy;
        logic         tc;
        logic         ready;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_value = '0;
    logic         auto_reload = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .auto_reload(auto_reload),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic push(input string tag, input logic [W-1:0] c, input logic b, input logic t);
        exp_t e;
        e.tag   = tag;
        e.count = c;
        e.busy  = b;
        e.tc    = t;
        e.ready = ~b;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare outputs against the oldest queued expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".count"}, 32'(count), 32'(e.count));
            check({e.tag, ".busy"},  32'(busy),  32'(e.busy));
            check({e.tag, ".tc"},    32'(tc),    32'(e.tc));
            check({e.tag, ".ready"}, 32'(load_ready), 32'(e.ready));
        end
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, ".count"}, 32'(count), 32'd0);
        check({tag, ".busy"},  32'(busy),  32'd0);
        check({tag, ".tc"},    32'(tc),    32'd0);
        check({tag, ".ready"}, 32'(load_ready), 32'd1);
    endtask

    task automatic load(input logic [W-1:0] v, input logic mode);
        load_valid  = 1'b1;
        load_value  = v;
        auto_reload = mode;
    endtask

    initial begin
        // Reset state
        #12;
        check_idle_now("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: one-shot load 5
        en = 1'b1;
        load(8'd5, 1'b0);
        push("t1_load", 8'd5, 1'b1, 1'b0);
        tick();
        load_valid = 1'b0;
        for (int v = 4; v >= 1; v--) begin
            push($sformatf("t1_cnt%0d", v), W'(v), 1'b1, 1'b0);
            tick();
        end
        push("t1_term", 8'd0, 1'b0, 1'b1);
        tick();
        push("t1_after", 8'd0, 1'b0, 1'b0);
        tick();

        // 2: auto-reload load 3, then abort at count 1
        load(8'd3, 1'b1);
        push("t2_load", 8'd3, 1'b1, 1'b0);
        tick();
        load_valid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            push($sformatf("t2_p%0d_2", p), 8'd2, 1'b1, 1'b0); tick();
            push($sformatf("t2_p%0d_1", p), 8'd1, 1'b1, 1'b0); tick();
            push($sformatf("t2_p%0d_rl", p), 8'd3, 1'b1, 1'b1); tick();
        end
        push("t2_2", 8'd2, 1'b1, 1'b0); tick();
        push("t2_1", 8'd1, 1'b1, 1'b0); tick();
        abort = 1'b1;
        push("t2_abort", 8'd0, 1'b0, 1'b0);
        tick();
        abort = 1'b0;

        // 3: pause at count 4 for two cycles
        load(8'd6, 1'b0);
        push("t3_load", 8'd6, 1'b1, 1'b0); tick();
        load_valid = 1'b0;
        push("t3_5", 8'd5, 1'b1, 1'b0); tick();
        push("t3_4", 8'd4, 1'b1, 1'b0); tick();
        en = 1'b0;
        push("t3_hold0", 8'd4, 1'b1, 1'b0); tick();
        push("t3_hold1", 8'd4, 1'b1, 1'b0); tick();
        en = 1'b1;
        push("t3_3", 8'd3, 1'b1, 1'b0); tick();
        push("t3_2", 8'd2, 1'b1, 1'b0); tick();
        push("t3_1", 8'd1, 1'b1, 1'b0); tick();
        push("t3_term", 8'd0, 1'b0, 1'b1); tick();

        // 4: load 9, load attempt while busy, abort at 2, then accepted load of 7
        load(8'd9, 1'b0);
        push("t4_load", 8'd9, 1'b1, 1'b0); tick();
        load(8'd7, 1'b0);
        for (int v = 8; v >= 2; v--) begin
            push($sformatf("t4_cnt%0d", v), W'(v), 1'b1, 1'b0);
            tick();
        end
        abort = 1'b1;
        push("t4_abort", 8'd0, 1'b0, 1'b0); tick();
        push("t4_reload7", 8'd7, 1'b1, 1'b0); tick();
        abort = 1'b0;
        load_valid = 1'b0;
        for (int v = 6; v >= 1; v--) begin
            push($sformatf("t4b_cnt%0d", v), W'(v), 1'b1, 1'b0);
            tick();
        end
        push("t4b_term", 8'd0, 1'b0, 1'b1); tick();

        // 5: zero-length load
        load(8'd0, 1'b0);
        push("t5_zero", 8'd0, 1'b0, 1'b1); tick();
        load_valid = 1'b0;
        push("t5_after", 8'd0, 1'b0, 1'b0); tick();

        // reload_q == 1: tc on every enabled cycle
        load(8'd1, 1'b1);
        push("r1_load", 8'd1, 1'b1, 1'b0); tick();
        load_valid = 1'b0;
        push("r1_tc0", 8'd1, 1'b1, 1'b1); tick();
        push("r1_tc1", 8'd1, 1'b1, 1'b1); tick();
        abort = 1'b1;
        push("r1_abort", 8'd0, 1'b0, 1'b0); tick();
        abort = 1'b0;

        // Max load value
        load(8'd255, 1'b0);
        push("max_load", 8'd255, 1'b1, 1'b0); tick();
        load_valid = 1'b0;
        push("max_254", 8'd254, 1'b1, 1'b0); tick();
        abort = 1'b1;
        push("max_abort", 8'd0, 1'b0, 1'b0); tick();
        abort = 1'b0;

        // 6: async reset mid-run at count 150
        load(8'd200, 1'b1);
        push("t6_load", 8'd200, 1'b1, 1'b0); tick();
        load_valid = 1'b0;
        for (int v = 199; v >= 150; v--) begin
            push($sformatf("t6_cnt%0d", v), W'(v), 1'b1, 1'b0);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle_now("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
        load(8'd2, 1'b0);
        push("t6b_load", 8'd2, 1'b1, 1'b0); tick();
        load_valid = 1'b0;
        push("t6b_1", 8'd1, 1'b1, 1'b0); tick();
        push("t6b_term", 8'd0, 1'b0, 1'b1); tick();
        push("t6b_idle", 8'd0, 1'b0, 1'b0); tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
